// File: rtl/counter_updown8_monitor_pkg.sv
// Shared constants for the up/down counter monitor: state codes, default widths
// and the step classes reported by the step classifier.
package counter_updown8_monitor_pkg;

  localparam int WIDTH_DEF     = 8;
  localparam int ERR_CNT_W_DEF = 8;

  localparam logic [2:0] UNPRIMED = 3'd0;
  localparam logic [2:0] HOLD     = 3'd1;
  localparam logic [2:0] UP       = 3'd2;
  localparam logic [2:0] DOWN     = 3'd3;
  localparam logic [2:0] ERR      = 3'd4;

  typedef enum logic [1:0] {
    D_HOLD = 2'd0,
    D_INC  = 2'd1,
    D_DEC  = 2'd2,
    D_BAD  = 2'd3
  } delta_cls_t;

endpackage

// File: rtl/counter_updown8_monitor_step_classifier.sv
// Combinational step check between two consecutive count samples; the modulo
// difference decides hold / +1 / -1 / illegal, plus whether the step wrapped.
module counter_updown8_monitor_step_classifier
  import counter_updown8_monitor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] cur,
  output delta_cls_t       cls,
  output logic             wrap
);

  logic [WIDTH-1:0] delta;

  assign delta = cur - prev;

  always_comb begin
    cls  = D_BAD;
    wrap = 1'b0;
    if (delta == '0) begin
      cls = D_HOLD;
    end else if (delta == WIDTH'(1)) begin
      cls  = D_INC;
      wrap = (prev == '1);
    end else if (delta == '1) begin
      cls  = D_DEC;
      wrap = (prev == '0);
    end
  end

endmodule

// File: rtl/counter_updown8_monitor.sv
// Passive monitor of an up/down counter's output bus: reconstructs direction and
// activity, flags illegal steps and wrap-arounds, and tallies errors.
//
//   state    | meaning
//   UNPRIMED | no reference sample yet; next sample only primes prev
//   HOLD     | last valid sample equal to the previous one
//   UP       | last valid sample was previous + 1
//   DOWN     | last valid sample was previous - 1
//   ERR      | last valid sample was an illegal jump (resyncs on next sample)
module counter_updown8_monitor
  import counter_updown8_monitor_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int ERR_CNT_W = ERR_CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic [WIDTH-1:0]     count_in,
  input  logic                 sample_en,
  input  logic                 clear,
  output logic [2:0]           state,
  output logic                 moving,
  output logic                 dir_up,
  output logic                 step_err,
  output logic                 wrap_evt,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic [WIDTH-1:0] prev;
  delta_cls_t       cls;
  logic             wrap;

  counter_updown8_monitor_step_classifier #(.WIDTH(WIDTH)) u_step_classifier (
    .prev (prev),
    .cur  (count_in),
    .cls  (cls),
    .wrap (wrap)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= UNPRIMED;
      moving    <= 1'b0;
      dir_up    <= 1'b0;
      step_err  <= 1'b0;
      wrap_evt  <= 1'b0;
      err_count <= '0;
      prev      <= '0;
    end else if (clear) begin
      // clear wins over a coincident sample, which is dropped
      state     <= UNPRIMED;
      moving    <= 1'b0;
      dir_up    <= 1'b0;
      step_err  <= 1'b0;
      wrap_evt  <= 1'b0;
      err_count <= '0;
      prev      <= '0;
    end else begin
      step_err <= 1'b0;
      wrap_evt <= 1'b0;
      if (sample_en) begin
        prev <= count_in;
        if (state == UNPRIMED) begin
          state  <= HOLD;
          moving <= 1'b0;
        end else begin
          unique case (cls)
            D_HOLD: begin
              state  <= HOLD;
              moving <= 1'b0;
            end
            D_INC: begin
              state    <= UP;
              moving   <= 1'b1;
              dir_up   <= 1'b1;
              wrap_evt <= wrap;
            end
            D_DEC: begin
              state    <= DOWN;
              moving   <= 1'b1;
              dir_up   <= 1'b0;
              wrap_evt <= wrap;
            end
            default: begin
              state    <= ERR;
              moving   <= 1'b0;
              step_err <= 1'b1;
              if (err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_updown8_monitor.sv
// Self-checking bench for counter_updown8_monitor: directed vector table, corner
// sequences (saturation, async reset) and randomized checks against a model.
module tb_counter_updown8_monitor;

  logic       clk;
  logic       resetN;
  logic [7:0] count_in;
  logic       sample_en;
  logic       clear;
  logic [2:0] state;
  logic       moving;
  logic       dir_up;
  logic       step_err;
  logic       wrap_evt;
  logic [7:0] err_count;

  int n_assert = 0;
  int n_fail   = 0;

  counter_updown8_monitor #(.WIDTH(8), .ERR_CNT_W(8)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .count_in  (count_in),
    .sample_en (sample_en),
    .clear     (clear),
    .state     (state),
    .moving    (moving),
    .dir_up    (dir_up),
    .step_err  (step_err),
    .wrap_evt  (wrap_evt),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit en;
    bit clr;
    int val;
    int st;
    int mov;
    int dir;
    int se;
    int we;
    int ec;
  } vec_t;

  vec_t vecs[$];

  // reference model state
  bit m_primed;
  int m_prev, m_st, m_mov, m_dir, m_se, m_we, m_ec;

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int st, input int mov, input int dir,
                         input int se, input int we, input int ec);
    chk({tag, " state"}, int'(state), st);
    chk({tag, " moving"}, int'(moving), mov);
    chk({tag, " dir_up"}, int'(dir_up), dir);
    chk({tag, " step_err"}, int'(step_err), se);
    chk({tag, " wrap_evt"}, int'(wrap_evt), we);
    chk({tag, " err_count"}, int'(err_count), ec);
  endtask

  task automatic drive(input bit en, input bit clr, input int val);
    @(negedge clk);
    sample_en = en;
    clear     = clr;
    count_in  = val[7:0];
    @(posedge clk);
    #1;
  endtask

  function automatic void addv(input bit en, input bit clr, input int val, input int st,
                               input int mov, input int dir, input int se, input int we,
                               input int ec);
    vec_t v;
    v.en = en; v.clr = clr; v.val = val; v.st = st; v.mov = mov;
    v.dir = dir; v.se = se; v.we = we; v.ec = ec;
    vecs.push_back(v);
  endfunction

  function automatic void model_step(input bit en, input bit clr, input int val);
    int d;
    if (clr) begin
      m_primed = 0; m_prev = 0; m_st = 0; m_mov = 0; m_dir = 0;
      m_se = 0; m_we = 0; m_ec = 0;
      return;
    end
    m_se = 0;
    m_we = 0;
    if (!en) return;
    if (!m_primed) begin
      m_primed = 1;
      m_st = 1;
      m_mov = 0;
    end else begin
      d = (val - m_prev + 256) % 256;
      if (d == 0) begin
        m_st = 1; m_mov = 0;
      end else if (d == 1) begin
        m_st = 2; m_mov = 1; m_dir = 1; m_we = (m_prev == 255) ? 1 : 0;
      end else if (d == 255) begin
        m_st = 3; m_mov = 1; m_dir = 0; m_we = (m_prev == 0) ? 1 : 0;
      end else begin
        m_st = 4; m_mov = 0; m_se = 1;
        m_ec = (m_ec < 255) ? m_ec + 1 : 255;
      end
    end
    m_prev = val;
  endfunction

  initial begin
    int last;
    resetN    = 1'b0;
    sample_en = 1'b0;
    clear     = 1'b0;
    count_in  = 8'd0;

    // en, clr, val | state, moving, dir_up, step_err, wrap_evt, err_count
    for (int i = 0; i < 5; i++) addv(1, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) addv(1, 0, i, 2, 1, 1, 0, 0, 0);
    addv(0, 1, 0,   0, 0, 0, 0, 0, 0);
    addv(1, 0, 254, 1, 0, 0, 0, 0, 0);
    addv(1, 0, 255, 2, 1, 1, 0, 0, 0);
    addv(1, 0, 0,   2, 1, 1, 0, 1, 0);
    addv(1, 0, 1,   2, 1, 1, 0, 0, 0);
    addv(1, 0, 0,   3, 1, 0, 0, 0, 0);
    addv(1, 0, 255, 3, 1, 0, 0, 1, 0);
    addv(0, 0, 77,  3, 1, 0, 0, 0, 0);
    addv(1, 0, 5,   4, 0, 0, 1, 0, 1);
    addv(1, 0, 6,   2, 1, 1, 0, 0, 1);
    addv(1, 0, 9,   4, 0, 1, 1, 0, 2);
    addv(1, 0, 10,  2, 1, 1, 0, 0, 2);
    addv(1, 0, 11,  2, 1, 1, 0, 0, 2);
    addv(1, 1, 42,  0, 0, 0, 0, 0, 0);
    addv(1, 0, 43,  1, 0, 0, 0, 0, 0);
    addv(1, 0, 44,  2, 1, 1, 0, 0, 0);
    addv(0, 0, 90,  2, 1, 1, 0, 0, 0);

    #100;
    resetN = 1'b1;
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].clr, vecs[i].val);
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].mov, vecs[i].dir,
              vecs[i].se, vecs[i].we, vecs[i].ec);
    end

    // saturation of the error tally over 300 illegal jumps
    drive(0, 1, 0);
    drive(1, 0, 0);
    for (int i = 1; i <= 300; i++) begin
      drive(1, 0, (i % 2 == 1) ? 128 : 0);
      chk($sformatf("sat%0d step_err", i), int'(step_err), 1);
      chk($sformatf("sat%0d err_count", i), int'(err_count), (i < 255) ? i : 255);
    end
    chk("sat state", int'(state), 4);

    // async reset while in DOWN with a nonzero error tally
    drive(0, 1, 0);
    drive(1, 0, 20);
    drive(1, 0, 50);
    drive(1, 0, 49);
    chk_all("pre_rst", 3, 1, 0, 0, 0, 1);
    resetN = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0, 0);
    #2;
    resetN = 1'b1;
    drive(1, 0, 48);
    chk_all("post_rst_prime", 1, 0, 0, 0, 0, 0);
    drive(1, 0, 47);
    chk_all("post_rst_down", 3, 1, 0, 0, 0, 0);

    // randomized run against the behavioural model
    drive(0, 1, 0);
    model_step(0, 1, 0);
    last = 0;
    for (int i = 0; i < 600; i++) begin
      bit en, clr;
      int r, val;
      en  = ($urandom % 4) != 0;
      clr = ($urandom % 40) == 0;
      r   = $urandom % 8;
      if (r < 2)      val = last;
      else if (r < 5) val = (last + 1) % 256;
      else if (r < 7) val = (last + 255) % 256;
      else            val = $urandom % 256;
      if (i < 40 && r < 5) val = 255 - (i % 2);
      drive(en, clr, val);
      model_step(en, clr, val);
      if (en && !clr) last = val;
      chk_all($sformatf("rnd%0d", i), m_st, m_mov, m_dir, m_se, m_we, m_ec);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
